// File: rtl/burst_mem_responder.sv
// -----------------------------------------------------------------------------
// burst_mem_responder
//
// Memory-side responder for the 4-beat x 64-bit burst protocol driven by the
// LLC-side cacheline adaptor. Holds 2**IDX_W lines of 256 bits and answers a
// read or write burst after a programmable access latency. It is the main
// memory model used for system simulation and FPGA bring-up.
//
// Parameters
//   LATENCY   cycles from request acceptance to the first beat (>= 1)
//   IDX_W     line-index width, index = address_i[5 +: IDX_W]
//
// Ports
//   clk        in   1   clock, all state on posedge
//   reset_n    in   1   synchronous active-low reset
//   address_i  in   32  byte address; [4:0] ignored, bits above the index alias
//   read_i     in   1   read request, held until the turnaround cycle
//   write_i    in   1   write request, held until the turnaround cycle
//   burst_i    in   64  write beat data, sampled at the end of each write beat
//   burst_o    out  64  read beat data, valid while resp_o=1 on a read
//   resp_o     out  1   beat strobe, four consecutive cycles per burst
//   err_o      out  1   sticky protocol-error flag, cleared only by reset
//
// Build option
//   BURST_MEM_RAND_LAT_EN  adds 0..7 pseudo-random wait cycles per request,
//                          taken from an 8-bit LFSR (seed 8'hA5 on reset).
//                          Undefined: latency is exactly LATENCY.
// -----------------------------------------------------------------------------
module burst_mem_responder #(
    parameter int LATENCY = 2,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        err_o
);

    localparam int LINES = 2 ** IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [1:0]         beat_r, beat_s;
    logic [15:0]        wait_r, wait_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic               op_wr_r, op_wr_s;
    logic               accept_s;
    logic               err_set_s;
    logic               commit_s;
    logic               req_s;
    logic               flip_s;
    logic [2:0]         extra_s;
    logic [15:0]        first_wait_s;
    logic [63:0]        rd_word_s;
    logic [255:0]       mem_r [LINES];
    logic               resp_r;
    logic [63:0]        burst_r;
    logic               err_r;

    // Offset bits and aliased upper bits are deliberately ignored.
    logic addr_unused_s;
    assign addr_unused_s = ^{address_i[4:0], address_i[31:5+IDX_W]};

    assign req_s  = read_i | write_i;
    // Seeing the opposite request from the latched op counts as a flip.
    assign flip_s = op_wr_r ? read_i : write_i;

`ifdef BURST_MEM_RAND_LAT_EN
    logic [7:0] lfsr_r;

    // LFSR for x^8+x^6+x^5+x^4+1, stepped once per accepted request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_r <= 8'hA5;
        end else if (accept_s) begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    assign extra_s = lfsr_r[2:0];
`else
    assign extra_s = 3'd0;
`endif

    // Number of WAIT cycles between acceptance and the first beat.
    assign first_wait_s = 16'(LATENCY - 1) + {13'd0, extra_s};

    // Read word for the beat about to be presented (new index when accepting).
    assign rd_word_s = mem_r[idx_s][{beat_s, 6'd0} +: 64];

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_s   = state_r;
        beat_s    = beat_r;
        wait_s    = wait_r;
        idx_s     = idx_r;
        op_wr_s   = op_wr_r;
        accept_s  = 1'b0;
        err_set_s = 1'b0;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    accept_s  = 1'b1;
                    idx_s     = address_i[5 +: IDX_W];
                    op_wr_s   = write_i;
                    err_set_s = read_i & write_i;
                    beat_s    = 2'd0;
                    if (first_wait_s == 16'd0) begin
                        state_s = ST_BEAT;
                    end else begin
                        state_s = ST_WAIT;
                        wait_s  = first_wait_s - 16'd1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!req_s) begin
                    err_set_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    err_set_s = flip_s;
                    if (wait_r == 16'd0) begin
                        state_s = ST_BEAT;
                        beat_s  = 2'd0;
                    end else begin
                        wait_s = wait_r - 16'd1;
                    end
                end
            end
            ST_BEAT: begin
                // An aborted beat is not committed; earlier beats stay written.
                if (!req_s) begin
                    err_set_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    err_set_s = flip_s;
                    commit_s  = op_wr_r;
                    if (beat_r == 2'd3) begin
                        state_s = ST_DONE;
                    end else begin
                        beat_s = beat_r + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and latched request registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            beat_r  <= 2'd0;
            wait_r  <= 16'd0;
            idx_r   <= '0;
            op_wr_r <= 1'b0;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            wait_r  <= wait_s;
            idx_r   <= idx_s;
            op_wr_r <= op_wr_s;
        end
    end

    // Registered outputs, aligned with the beat state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_r  <= 1'b0;
            burst_r <= 64'd0;
            err_r   <= 1'b0;
        end else begin
            resp_r  <= (state_s == ST_BEAT);
            burst_r <= ((state_s == ST_BEAT) && !op_wr_s) ? rd_word_s : 64'd0;
            err_r   <= err_r | err_set_s;
        end
    end

    // Per-beat write commit; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (reset_n && commit_s) begin
            mem_r[idx_r][{beat_r, 6'd0} +: 64] <= burst_i;
        end
    end

    assign resp_o  = resp_r;
    assign burst_o = burst_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_burst_mem_responder.sv
module tb_burst_mem_responder;

    logic        clk;
    logic        reset_n;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        err_o;

    int n_cmp;
    int n_err;

    localparam logic [255:0] L1 = {64'h1111111111111111, 64'h2222222222222222,
                                   64'h3333333333333333, 64'h4444444444444444};
    localparam logic [255:0] L2 = {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB,
                                   64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD};
    localparam logic [255:0] L3 = {64'h5555555555555555, 64'h6666666666666666,
                                   64'h7777777777777777, 64'h8888888888888888};
    localparam logic [255:0] L4 = {64'h0101010101010101, 64'h0202020202020202,
                                   64'h0303030303030303, 64'h0404040404040404};
    // L1 with beats 0-1 replaced by L3's beats 0-1.
    localparam logic [255:0] L13 = {64'h1111111111111111, 64'h2222222222222222,
                                    64'h7777777777777777, 64'h8888888888888888};

    localparam int EV_NONE  = 0;
    localparam int EV_DROP  = 1;
    localparam int EV_RESET = 2;
    localparam int EV_FLIP  = 3;

    burst_mem_responder #(.LATENCY(2), .IDX_W(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .resp_o    (resp_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One burst. ev fires at the start of beat ev_beat.
    task automatic xfer(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [255:0] wline, input int ev, input int ev_beat,
                        output logic [255:0] rline, output int lat, output int nbeats);
        int k;
        rline  = '0;
        nbeats = 0;
        @(posedge clk); #1;
        address_i = addr;
        write_i   = wr;
        read_i    = rd;
        @(posedge clk); #1;              // edge N: request accepted
        address_i = 32'hFFFF_FFE0;        // must be ignored mid-burst
        k = 0;
        while (!resp_o && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        lat = k + 1;
        while (resp_o && nbeats < 8) begin
            if (nbeats == ev_beat) begin
                if (ev == EV_DROP) begin
                    read_i  = 1'b0;
                    write_i = 1'b0;
                end else if (ev == EV_RESET) begin
                    reset_n = 1'b0;
                end else if (ev == EV_FLIP) begin
                    read_i  = 1'b0;
                    write_i = 1'b1;
                end
            end
            if (wr) burst_i = wline[64*nbeats +: 64];
            if (nbeats < 4) rline[64*nbeats +: 64] = burst_o;
            nbeats++;
            @(posedge clk); #1;
        end
        reset_n = 1'b1;
        read_i  = 1'b0;
        write_i = 1'b0;
        burst_i = 64'hF0F0F0F0F0F0F0F0;
    endtask

    task automatic check_line(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        for (int b = 0; b < 4; b++) begin
            check_val($sformatf("%s_b%0d", tag, b), obs[64*b +: 64], exp[64*b +: 64]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    logic [255:0] rl;
    int lat;
    int nb;

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        address_i = 32'd0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = 64'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("rst_resp", {63'd0, resp_o}, 64'd0);
        check_val("rst_burst", burst_o, 64'd0);
        check_val("rst_err", {63'd0, err_o}, 64'd0);
        reset_n = 1'b1;

        // Basic write then read.
        xfer(1'b1, 1'b0, 32'h40, L1, EV_NONE, 0, rl, lat, nb);
        check_val("wr_lat", 64'(lat), 64'd2);
        check_val("wr_beats", 64'(nb), 64'd4);
        check_val("wr_burst_o_zero", rl[63:0], 64'd0);
        check_val("wr_err", {63'd0, err_o}, 64'd0);

        xfer(1'b0, 1'b1, 32'h40, '0, EV_NONE, 0, rl, lat, nb);
        check_val("rd_lat", 64'(lat), 64'd2);
        check_val("rd_beats", 64'(nb), 64'd4);
        check_line("rd_40", rl, L1);
        check_val("rd_done_burst", burst_o, 64'd0);
        check_val("rd_err", {63'd0, err_o}, 64'd0);

        // Alias and ignored offset bits.
        xfer(1'b0, 1'b1, 32'h240, '0, EV_NONE, 0, rl, lat, nb);
        check_line("alias", rl, L1);
        xfer(1'b0, 1'b1, 32'h5F, '0, EV_NONE, 0, rl, lat, nb);
        check_line("offset", rl, L1);

        // Second line does not disturb the first.
        xfer(1'b1, 1'b0, 32'h60, L2, EV_NONE, 0, rl, lat, nb);
        xfer(1'b0, 1'b1, 32'h60, '0, EV_NONE, 0, rl, lat, nb);
        check_line("rd_60", rl, L2);
        xfer(1'b0, 1'b1, 32'h40, '0, EV_NONE, 0, rl, lat, nb);
        check_line("rd_40_again", rl, L1);

        // Write aborted at beat 2: beats 0-1 committed.
        xfer(1'b1, 1'b0, 32'h40, L3, EV_DROP, 2, rl, lat, nb);
        check_val("abort_beats", 64'(nb), 64'd3);
        check_val("abort_err", {63'd0, err_o}, 64'd1);
        check_val("abort_resp", {63'd0, resp_o}, 64'd0);
        xfer(1'b0, 1'b1, 32'h40, '0, EV_NONE, 0, rl, lat, nb);
        check_line("partial", rl, L13);
        check_val("err_sticky", {63'd0, err_o}, 64'd1);
        do_reset();
        check_val("err_cleared", {63'd0, err_o}, 64'd0);

        // Op flip on a read: data still read, no write, error flagged.
        xfer(1'b0, 1'b1, 32'h60, '0, EV_FLIP, 1, rl, lat, nb);
        check_line("flip_rd", rl, L2);
        check_val("flip_err", {63'd0, err_o}, 64'd1);
        xfer(1'b0, 1'b1, 32'h60, '0, EV_NONE, 0, rl, lat, nb);
        check_line("flip_nowr", rl, L2);
        do_reset();

        // Both requests high: write wins, error flagged.
        xfer(1'b1, 1'b1, 32'h80, L4, EV_NONE, 0, rl, lat, nb);
        check_val("both_err", {63'd0, err_o}, 64'd1);
        check_val("both_beats", 64'(nb), 64'd4);
        xfer(1'b0, 1'b1, 32'h80, '0, EV_NONE, 0, rl, lat, nb);
        check_line("both_wr", rl, L4);
        do_reset();

        // Reset during beat 2 of a both-high write.
        xfer(1'b1, 1'b0, 32'hA0, L1, EV_NONE, 0, rl, lat, nb);
        xfer(1'b1, 1'b1, 32'hA0, L3, EV_RESET, 2, rl, lat, nb);
        check_val("rst_mid_beats", 64'(nb), 64'd3);
        check_val("rst_mid_resp", {63'd0, resp_o}, 64'd0);
        check_val("rst_mid_err", {63'd0, err_o}, 64'd0);
        xfer(1'b0, 1'b1, 32'hA0, '0, EV_NONE, 0, rl, lat, nb);
        check_line("rst_partial", rl, L13);
        check_val("rst_rd_lat", 64'(lat), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
